avr_cpu_alu: RTL and testbench
==============================

AVR_CPU_ALU -- requirements
Module: avr_cpu_alu

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 opcode  input  3  operation select (see REQ-010).
REQ-005 use_carry  input  1  1 = ADD becomes ADC and SUB becomes SBC, using status_in[0].
REQ-006 r_in  input  8  source operand Rr.
REQ-007 d_in  input  8  destination operand Rd.
REQ-008 status_in  input  8  current SREG, bits 7..0 = I T H S V N Z C.
REQ-009 out  output  8  registered result; status_out  output  8  registered new SREG, same bit layout as status_in.

Function
REQ-010 The opcode map SHALL be:
- 000 ADD/ADC: out = d + r (+C).
- 001 SUB/SBC: out = d - r (-C).
- 010 AND; 011 OR; 100 EOR: out = d op r.
- 101 COM: out = ~d.
- 110 NEG: out = 0 - d.
- 111 MOV: out = r.
REQ-011 On each rising clk edge with rst_n=1, out and status_out SHALL take the result of the current inputs; latency is exactly 1 cycle, and a new operation can start every cycle.
REQ-012 All arithmetic SHALL be modulo 256; the carry/borrow out of bit 7 goes only to C.
REQ-013 status_out[7:6] (I, T) SHALL always equal status_in[7:6].
REQ-014 For every flag-updating op: N = R7, S = N^V, Z = (R == 0).
- Exception: under SBC, Z = status_in[1] & (R == 0).
REQ-015 ADD/ADC flags:
- C = carry out of bit 7.
- H = carry out of bit 3.
- V = d7&r7&!R7 | !d7&!r7&R7.
REQ-016 SUB/SBC flags:
- C = borrow from bit 7, i.e. unsigned d < r + Cin.
- H = borrow from bit 3.
- V = d7&!r7&!R7 | !d7&r7&R7.
REQ-017 AND/OR/EOR flags: V = 0; C and H SHALL be copied from status_in.
REQ-018 COM flags: C = 1, V = 0, H copied from status_in.
REQ-019 NEG flags:
- C = (R != 0).
- V = (R == 0x80).
- H = R3 | d3.
REQ-020 MOV: status_out SHALL equal status_in unchanged.
REQ-021 use_carry SHALL be ignored for opcodes other than 000 and 001.
REQ-022 The block SHALL contain no internal state other than the out and status_out registers.

Reset
REQ-023 While rst_n=0 at a clk edge, out SHALL become 0x00 and status_out SHALL become 0x00, overriding any operation.
REQ-024 The first edge with rst_n=1 SHALL produce a valid result with no extra warm-up cycle.

Configuration
REQ-025 Macro AVR_CPU_ALU_UNARY_EN:
- When defined, opcodes 101 (COM) and 110 (NEG) SHALL behave per REQ-010/018/019.
- When undefined, 101 and 110 SHALL behave exactly as 111 (MOV: out = r, flags unchanged), and the COM/NEG logic SHALL be absent.

Verification
REQ-026 SUB: opcode=001, use_carry=0, r=40, d=50, status_in=0x00 -> next cycle out=0x0A, status_out=0x20 (H only).
REQ-027 SUB: same setup but d=240 -> out=0xC8 (200), status_out=0x34 (H, S, N).
REQ-028 ADC: opcode=000, use_carry=1, r=0xFF, d=0x00, status_in=0x01 -> out=0x00, status_out=0x23 (H, Z, C).
REQ-029 SBC zero rule: opcode=001, use_carry=1, r=d=0x10, status_in=0x00 -> out=0x00, Z=0.
- Repeating with status_in=0x02 -> Z=1.
REQ-030 NEG: opcode=110, d=0x80, status_in=0xC0 -> out=0x80, status_out=0xCD (I, T, V, N, C).
- Without AVR_CPU_ALU_UNARY_EN the same stimulus with r=0x55 -> out=0x55, status_out=0xC0.
REQ-031 Reset: assert rst_n=0 mid-stream for one edge -> out=0x00 and status_out=0x00 after that edge.
- The operation applied on the next edge with rst_n=1 is correct.

Source files
------------

// File: rtl/avr_cpu_alu.sv
// AVR-style 8-bit ALU: one registered result and SREG update per cycle.
// Optional COM/NEG support is enabled by defining AVR_CPU_ALU_UNARY_EN.
module avr_cpu_alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       use_carry,
  input  logic [7:0] r_in,
  input  logic [7:0] d_in,
  input  logic [7:0] status_in,
  output logic [7:0] out,
  output logic [7:0] status_out
);

  localparam int unsigned DW = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
`ifdef AVR_CPU_ALU_UNARY_EN
  localparam logic [2:0] OP_COM = 3'b101;
  localparam logic [2:0] OP_NEG = 3'b110;
`endif

  logic [DW-1:0] r_out;
  logic [DW-1:0] r_status;

  logic          w_cin;
  logic [DW:0]   w_add9;
  logic [DW:0]   w_sub9;
  logic [DW-1:0] w_res;
  logic [DW-1:0] w_status;
  logic          w_upd;
  logic          w_h;
  logic          w_v;
  logic          w_c;
  logic          w_z;
  logic          w_n;

  // Carry-in only matters for the arithmetic opcodes.
  assign w_cin  = use_carry & status_in[0];
  assign w_add9 = {1'b0, d_in} + {1'b0, r_in} + (DW+1)'(w_cin);
  assign w_sub9 = {1'b0, d_in} - {1'b0, r_in} - (DW+1)'(w_cin);

  always_comb begin
    w_res = r_in;
    w_upd = 1'b0;
    w_h   = status_in[5];
    w_v   = status_in[3];
    w_c   = status_in[0];
    w_z   = 1'b0;
    w_n   = 1'b0;
    w_status = status_in;

    case (opcode)
      OP_ADD: begin
        w_res = w_add9[DW-1:0];
        w_upd = 1'b1;
        w_c   = w_add9[DW];
        w_h   = (d_in[3] & r_in[3]) | (r_in[3] & ~w_res[3]) | (~w_res[3] & d_in[3]);
        w_v   = (d_in[7] & r_in[7] & ~w_res[7]) | (~d_in[7] & ~r_in[7] & w_res[7]);
      end
      OP_SUB: begin
        w_res = w_sub9[DW-1:0];
        w_upd = 1'b1;
        w_c   = w_sub9[DW];
        w_h   = (~d_in[3] & r_in[3]) | (r_in[3] & w_res[3]) | (w_res[3] & ~d_in[3]);
        w_v   = (d_in[7] & ~r_in[7] & ~w_res[7]) | (~d_in[7] & r_in[7] & w_res[7]);
      end
      OP_AND: begin
        w_res = d_in & r_in;
        w_upd = 1'b1;
        w_v   = 1'b0;
      end
      OP_OR: begin
        w_res = d_in | r_in;
        w_upd = 1'b1;
        w_v   = 1'b0;
      end
      OP_EOR: begin
        w_res = d_in ^ r_in;
        w_upd = 1'b1;
        w_v   = 1'b0;
      end
`ifdef AVR_CPU_ALU_UNARY_EN
      OP_COM: begin
        w_res = ~d_in;
        w_upd = 1'b1;
        w_c   = 1'b1;
        w_v   = 1'b0;
      end
      OP_NEG: begin
        w_res = DW'(8'd0 - d_in);
        w_upd = 1'b1;
        w_c   = (w_res != '0);
        w_v   = (w_res == 8'h80);
        w_h   = w_res[3] | d_in[3];
      end
`endif
      default: begin
        w_res = r_in;
        w_upd = 1'b0;
      end
    endcase

    // SBC chains Z across bytes so multi-byte compares see the full zero.
    w_n = w_res[7];
    w_z = (w_res == '0);
    if (opcode == OP_SUB && use_carry)
      w_z = w_z & status_in[1];

    if (w_upd)
      w_status = {status_in[7:6], w_h, w_n ^ w_v, w_v, w_n, w_z, w_c};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_status <= '0;
    end else begin
      r_out    <= w_res;
      r_status <= w_status;
    end
  end

  assign out        = r_out;
  assign status_out = r_status;

endmodule

// File: tb/tb_avr_cpu_alu.sv
// Directed-vector bench for avr_cpu_alu; expectations switch on AVR_CPU_ALU_UNARY_EN.
module tb_avr_cpu_alu;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       use_carry;
  logic [7:0] r_in;
  logic [7:0] d_in;
  logic [7:0] status_in;
  logic [7:0] out;
  logic [7:0] status_out;

  int n_checks;
  int n_fails;

  avr_cpu_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .use_carry  (use_carry),
    .r_in       (r_in),
    .d_in       (d_in),
    .status_in  (status_in),
    .out        (out),
    .status_out (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Drive one operation, clock it once, check both registered outputs.
  task automatic run_op(input string tag, input logic [2:0] op, input logic uc,
                        input logic [7:0] r, input logic [7:0] d, input logic [7:0] st,
                        input logic [7:0] exp_out, input logic [7:0] exp_st);
    opcode    = op;
    use_carry = uc;
    r_in      = r;
    d_in      = d;
    status_in = st;
    @(posedge clk);
    #1;
    check_eq({tag, ".out"}, out, exp_out);
    check_eq({tag, ".sreg"}, status_out, exp_st);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    opcode    = 3'b000;
    use_carry = 1'b0;
    r_in      = 8'h12;
    d_in      = 8'h34;
    status_in = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.out", out, 8'h00);
    check_eq("reset.sreg", status_out, 8'h00);

    rst_n = 1'b1;
    run_op("sub_basic",  3'b001, 1'b0, 8'd40,  8'd50,  8'h00, 8'h0A, 8'h20);
    run_op("sub_neg",    3'b001, 1'b0, 8'd40,  8'd240, 8'h00, 8'hC8, 8'h34);
    run_op("adc_wrap",   3'b000, 1'b1, 8'hFF,  8'h00,  8'h01, 8'h00, 8'h23);
    run_op("sbc_z0",     3'b001, 1'b1, 8'h10,  8'h10,  8'h00, 8'h00, 8'h00);
    run_op("sbc_z1",     3'b001, 1'b1, 8'h10,  8'h10,  8'h02, 8'h00, 8'h02);
    run_op("add_ovf",    3'b000, 1'b0, 8'h01,  8'h7F,  8'h01, 8'h80, 8'h2C);
    run_op("add_noc",    3'b000, 1'b0, 8'h20,  8'h10,  8'hC1, 8'h30, 8'hC0);
    run_op("and",        3'b010, 1'b1, 8'h3C,  8'hF0,  8'h21, 8'h30, 8'h21);
    run_op("or",         3'b011, 1'b0, 8'h01,  8'h80,  8'h08, 8'h81, 8'h14);
    run_op("eor",        3'b100, 1'b0, 8'h5A,  8'h5A,  8'h20, 8'h00, 8'h22);
`ifdef AVR_CPU_ALU_UNARY_EN
    run_op("com",        3'b101, 1'b1, 8'h33,  8'h00,  8'h20, 8'hFF, 8'h35);
    run_op("neg_80",     3'b110, 1'b0, 8'h55,  8'h80,  8'hC0, 8'h80, 8'hCD);
    run_op("neg_00",     3'b110, 1'b1, 8'h12,  8'h00,  8'h3F, 8'h00, 8'h02);
    run_op("neg_01",     3'b110, 1'b0, 8'h12,  8'h01,  8'h00, 8'hFF, 8'h35);
`else
    run_op("com_mov",    3'b101, 1'b1, 8'h33,  8'h00,  8'h20, 8'h33, 8'h20);
    run_op("neg_80_mov", 3'b110, 1'b0, 8'h55,  8'h80,  8'hC0, 8'h55, 8'hC0);
    run_op("neg_00_mov", 3'b110, 1'b1, 8'h12,  8'h00,  8'h3F, 8'h12, 8'h3F);
    run_op("neg_01_mov", 3'b110, 1'b0, 8'h12,  8'h01,  8'h00, 8'h12, 8'h00);
`endif
    run_op("mov",        3'b111, 1'b1, 8'hA5,  8'h3C,  8'hFF, 8'hA5, 8'hFF);
    run_op("sub_borrow", 3'b001, 1'b0, 8'h01,  8'h00,  8'h00, 8'hFF, 8'h35);
    run_op("sub_ovf",    3'b001, 1'b0, 8'h01,  8'h80,  8'h00, 8'h7F, 8'h38);
    run_op("sbc_chain",  3'b001, 1'b1, 8'h0F,  8'h10,  8'h03, 8'h00, 8'h22);

    // Reset for one edge mid-stream, with a live operation on the inputs.
    rst_n     = 1'b0;
    opcode    = 3'b000;
    use_carry = 1'b0;
    r_in      = 8'h11;
    d_in      = 8'h22;
    status_in = 8'hC0;
    @(posedge clk);
    #1;
    check_eq("midreset.out", out, 8'h00);
    check_eq("midreset.sreg", status_out, 8'h00);
    rst_n = 1'b1;
    run_op("post_reset", 3'b000, 1'b1, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
